// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared opcodes, ack code and FSM state types for comm_master
package comm_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_HI  = 2'd1,
        SEND_MID = 2'd2,
        SEND_LO  = 2'd3
    } frm_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_trx.sv
// rtl/uart_trx.sv - 8N1 UART transmitter and receiver sharing one baud divisor
module uart_trx
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rdy
);

    localparam int CW = 12;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

    logic [CW-1:0] tx_baud;
    logic [3:0]    tx_bit;
    logic          tx_busy;
    logic [9:0]    tx_shift;

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] rx_baud;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          start_det, rx_sample, stop_smp, start_bad;

    // Stop bit is the last bit shifted out; done fires on its final cycle so
    // a new trmt in the same cycle follows with no idle gap.
    assign tx_done = tx_busy && (tx_baud == BAUD_LAST) && (tx_bit == 4'd9);
    assign tx      = tx_shift[0];

    // Transmit shifter: ones fill in from the top so the line idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (trmt) begin
            tx_busy  <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_shift <= {1'b1, tx_data, 1'b0};
        end else if (tx_busy) begin
            if (tx_baud == BAUD_LAST) begin
                tx_baud <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_baud <= tx_baud + CW'(1);
            end
        end
    end

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_det = (rx_state == RX_IDLE) && rx_prev && !rx_sync;
    assign rx_sample = (rx_state == RX_RECV) && (rx_baud == '0);
    assign start_bad = rx_sample && (rx_bit == 4'd0) && rx_sync;
    assign stop_smp  = rx_sample && (rx_bit == 4'd9);

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    // Receiver next state: leave on a falling edge, return on glitch or stop sample.
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE: if (start_det) rx_state_nxt = RX_RECV;
            RX_RECV: if (start_bad || stop_smp) rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receive counters: half a bit to mid start, then a full bit per sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (start_det) begin
            rx_baud <= BAUD_HALF;
            rx_bit  <= '0;
        end else if (rx_sample) begin
            rx_baud <= BAUD_LAST;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit != 4'd0 && rx_bit != 4'd9) rx_shift <= {rx_sync, rx_shift[7:1]};
        end else if (rx_state == RX_RECV) begin
            rx_baud <= rx_baud - CW'(1);
        end
    end

    // Received byte and ready flag; a completed byte beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
        end else if (stop_smp) begin
            rx_data <= rx_shift;
            rx_rdy  <= 1'b1;
        end else if (clr_rdy || start_det) begin
            rx_rdy  <= 1'b0;
        end
    end

endmodule

// File: rtl/comm_master.sv
// rtl/comm_master.sv - sends 3-byte command frames and holds the last response byte
module comm_master
    import comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        snd_cmd,
    output logic        frm_snt,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    input  logic        clr_resp_rdy
);

    frm_state_t  state, state_nxt;
    logic [23:0] frame;
    logic        trmt, tx_done, set_frm, clr_frm;
    logic [7:0]  tx_byte;

    uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .trmt    (trmt),
        .tx_data (tx_byte),
        .tx      (TX),
        .tx_done (tx_done),
        .rx_data (resp),
        .rx_rdy  (resp_rdy),
        .clr_rdy (clr_resp_rdy)
    );

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Advance one byte per transmitter done; snd_cmd only counts in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (snd_cmd) state_nxt = SEND_HI;
            SEND_HI:  if (tx_done) state_nxt = SEND_MID;
            SEND_MID: if (tx_done) state_nxt = SEND_LO;
            SEND_LO:  if (tx_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Byte launch and frame-sent controls; the first byte comes straight from
    // cmd because the frame register only loads on the same edge.
    always_comb begin
        trmt    = 1'b0;
        set_frm = 1'b0;
        clr_frm = 1'b0;
        tx_byte = frame[23:16];
        case (state)
            IDLE: begin
                tx_byte = cmd;
                trmt    = snd_cmd;
                clr_frm = snd_cmd;
            end
            SEND_HI: begin
                tx_byte = frame[15:8];
                trmt    = tx_done;
            end
            SEND_MID: begin
                tx_byte = frame[7:0];
                trmt    = tx_done;
            end
            SEND_LO:  set_frm = tx_done;
            default: ;
        endcase
    end

    // Capture the frame at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst)                          frame <= '0;
        else if (state == IDLE && snd_cmd) frame <= {cmd, data};
    end

    // Frame-sent level flag.
    always_ff @(posedge clk) begin
        if (rst)          frm_snt <= 1'b0;
        else if (clr_frm) frm_snt <= 1'b0;
        else if (set_frm) frm_snt <= 1'b1;
    end

endmodule

// File: tb/tb_comm_master.sv
// tb/tb_comm_master.sv - scoreboard bench for comm_master at BAUD_DIV=16
module tb_comm_master;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst, RX, TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        snd_cmd, frm_snt, resp_rdy, clr_resp_rdy;
    logic [7:0]  resp;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_snd   = 0;
    int n_rx    = 0;
    int n0;
    bit mon_en  = 1'b1;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_resp[$];
    logic [7:0] mon_b;
    logic       mon_start, mon_stop;

    comm_master #(.BAUD_DIV(BD)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX           (RX),
        .TX           (TX),
        .cmd          (cmd),
        .data         (data),
        .snd_cmd      (snd_cmd),
        .frm_snt      (frm_snt),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .clr_resp_rdy (clr_resp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference UART receiver on TX; pops the expected byte on each decode.
    initial begin
        forever begin
            @(negedge TX);
            repeat (BD / 2) @(negedge clk);
            mon_start = TX;
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                mon_b[i] = TX;
            end
            repeat (BD) @(negedge clk);
            mon_stop = TX;
            if (mon_en) begin
                n_rx++;
                check("tx_start_bit", 32'(mon_start), 32'd0);
                check("tx_stop_bit", 32'(mon_stop), 32'd1);
                if (exp_tx.size() == 0) check("tx_unexpected_byte", 32'(mon_b), 32'hFFFF_FFFF);
                else                    check("tx_byte", 32'(mon_b), 32'(exp_tx.pop_front()));
            end
        end
    end

    // Response scoreboard: each rise of resp_rdy consumes one expected byte.
    initial begin
        forever begin
            @(posedge resp_rdy);
            @(negedge clk);
            if (exp_resp.size() == 0) check("resp_unexpected", 32'(resp), 32'hFFFF_FFFF);
            else                      check("resp_sb", 32'(resp), 32'(exp_resp.pop_front()));
        end
    end

    task automatic send(input logic [7:0] c, input logic [15:0] d, input bit push, input bit scramble);
        @(negedge clk);
        cmd = c; data = d; snd_cmd = 1'b1;
        t_snd = cyc;
        if (push) begin
            exp_tx.push_back(c);
            exp_tx.push_back(d[15:8]);
            exp_tx.push_back(d[7:0]);
        end
        @(negedge clk);
        snd_cmd = 1'b0;
        if (scramble) begin
            cmd = ~c; data = ~d;
        end
        check("frm_snt_cleared", 32'(frm_snt), 32'd0);
    endtask

    task automatic wait_frm();
        int n = 0;
        int lat;
        while (!frm_snt && n < 40 * BD) begin
            @(negedge clk);
            n++;
        end
        check("frm_snt_set", 32'(frm_snt), 32'd1);
        lat = cyc - t_snd - 1;
        check("frm_latency_480pm2", 32'(lat >= 30 * BD - 2 && lat <= 30 * BD + 2), 32'd1);
        @(negedge clk);
        check("tx_idle_after_frame", 32'(TX), 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b);
        exp_resp.push_back(b);
        @(negedge clk);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = 1'b1;
        check("resp_rdy_before_stop", 32'(resp_rdy), 32'd0);
        repeat (BD) @(negedge clk);
        check("resp_rdy_after_stop", 32'(resp_rdy), 32'd1);
        check("resp_value", 32'(resp), 32'(b));
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; RX = 1'b1; cmd = '0; data = '0; snd_cmd = 1'b0; clr_resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_frm_snt", 32'(frm_snt), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        rst = 1'b0;

        // Basic frame 02 00 FA.
        n0 = n_rx;
        send(8'h02, 16'h00FA, 1'b1, 1'b0);
        wait_frm();
        repeat (12 * BD) @(negedge clk);
        check("t1_byte_count", 32'(n_rx - n0), 32'd3);

        // Responses A5 then C0, with a clear in between.
        drive_rx(8'hA5);
        pulse_clr();
        check("clr_resp_rdy", 32'(resp_rdy), 32'd0);
        drive_rx(8'hC0);

        // One-cycle glitch on RX in idle.
        pulse_clr();
        @(negedge clk); RX = 1'b0;
        @(negedge clk); RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check("glitch_resp_rdy", 32'(resp_rdy), 32'd0);
        check("glitch_resp", 32'(resp), 32'hC0);

        // snd_cmd during SEND_MID is ignored.
        n0 = n_rx;
        send(8'h02, 16'h1234, 1'b1, 1'b0);
        repeat (15 * BD) @(negedge clk);
        cmd = 8'h07; data = 16'h0000; snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        wait_frm();
        repeat (15 * BD) @(negedge clk);
        check("t3_no_fourth_byte", 32'(n_rx - n0), 32'd3);
        send(8'h07, 16'h0000, 1'b1, 1'b0);
        wait_frm();
        repeat (12 * BD) @(negedge clk);

        // Inputs change right after snd_cmd.
        send(8'h04, 16'hABCD, 1'b1, 1'b1);
        wait_frm();
        repeat (12 * BD) @(negedge clk);

        // Reset during SEND_HI.
        drive_rx(8'h5A);
        mon_en = 1'b0;
        send(8'h05, 16'h1234, 1'b0, 1'b0);
        repeat (2 * BD + 6) @(negedge clk);
        check("tx_low_pre_rst", 32'(TX), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 32'(TX), 32'd1);
        check("rst_mid_frm_snt", 32'(frm_snt), 32'd0);
        check("rst_mid_resp_rdy", 32'(resp_rdy), 32'd0);
        rst = 1'b0;
        repeat (12 * BD) @(negedge clk);
        check("rst_no_late_frm_snt", 32'(frm_snt), 32'd0);
        mon_en = 1'b1;
        n0 = n_rx;
        send(8'h08, 16'h0000, 1'b1, 1'b0);
        wait_frm();
        repeat (12 * BD) @(negedge clk);
        check("t6_byte_count", 32'(n_rx - n0), 32'd3);

        check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
        check("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
